// File: rtl/registrador_sequencia.sv
// Circular sequence register: appends entries and reads them back by logical index (0 = oldest).
// Define REGISTRADOR_SEQUENCIA_SOBRESCRITA_EN to overwrite the oldest entry when full instead of flagging erro.
module registrador_sequencia #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             zera,
    input  logic             escreve,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    endereco,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] ultimo,
    output logic [AW:0]      contagem,
    output logic             vazio,
    output logic             cheio,
    output logic             erro
);

`ifdef REGISTRADOR_SEQUENCIA_SOBRESCRITA_EN
    localparam bit SOBRESCRITA = 1'b1;
`else
    localparam bit SOBRESCRITA = 1'b0;
`endif

    localparam logic [AW-1:0] PTR_UM  = AW'(1);
    localparam logic [AW:0]   CNT_UM  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    base_q, base_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] ultimo_q, ultimo_d;
    logic             erro_q, erro_d;
    logic             mem_we;
    logic [AW-1:0]    rd_idx;
    logic             rd_valid;

    assign cheio    = (cnt_q == CNT_MAX);
    assign vazio    = (cnt_q == '0);
    assign rd_idx   = base_q + endereco;
    assign rd_valid = ({1'b0, endereco} < cnt_q);

    // Read uses pre-edge pointers/count, so a same-edge write only shows up one cycle later.
    always_comb begin
        base_d   = base_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        ultimo_d = ultimo_q;
        erro_d   = erro_q;
        mem_we   = 1'b0;
        q_d      = rd_valid ? mem_q[rd_idx] : '0;
        if (zera) begin
            base_d   = '0;
            wr_d     = '0;
            cnt_d    = '0;
            ultimo_d = '0;
            erro_d   = 1'b0;
            q_d      = '0;
        end else if (escreve) begin
            if (!cheio) begin
                mem_we   = 1'b1;
                wr_d     = wr_q + PTR_UM;
                cnt_d    = cnt_q + CNT_UM;
                ultimo_d = D;
            end else if (SOBRESCRITA) begin
                mem_we   = 1'b1;
                wr_d     = wr_q + PTR_UM;
                base_d   = base_q + PTR_UM;
                ultimo_d = D;
            end else begin
                erro_d   = 1'b1;
            end
        end
    end

    // Storage is never cleared; stale entries stay hidden behind contagem.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[wr_q] <= D;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            base_q   <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            q_q      <= '0;
            ultimo_q <= '0;
            erro_q   <= 1'b0;
        end else begin
            base_q   <= base_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            ultimo_q <= ultimo_d;
            erro_q   <= erro_d;
        end
    end

    assign Q        = q_q;
    assign ultimo   = ultimo_q;
    assign contagem = cnt_q;
    assign erro     = erro_q;

endmodule

// File: tb/tb_registrador_sequencia.sv
// Bench for registrador_sequencia: directed scenarios plus random traffic against a queue-based model.
// Honours REGISTRADOR_SEQUENCIA_SOBRESCRITA_EN so the same bench covers both full-buffer behaviours.
module tb_registrador_sequencia;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  // clock / reset
  logic             clock;
  logic             clear_n;
  logic             zera;
  logic             escreve;
  logic [WIDTH-1:0] D;
  logic [AW-1:0]    endereco;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] ultimo;
  logic [AW:0]      contagem;
  logic             vazio;
  logic             cheio;
  logic             erro;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  registrador_sequencia #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .clear_n  (clear_n),
    .zera     (zera),
    .escreve  (escreve),
    .D        (D),
    .endereco (endereco),
    .Q        (Q),
    .ultimo   (ultimo),
    .contagem (contagem),
    .vazio    (vazio),
    .cheio    (cheio),
    .erro     (erro)
  );

  // scoreboard: logical contents, oldest first, plus expected registered outputs
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_ult;
  logic             m_err;
  int               n_cmp;
  int               n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_q   = '0;
    m_ult = '0;
    m_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_Q"},        32'(Q),        32'(m_q));
    chk({tag, "_ultimo"},   32'(ultimo),   32'(m_ult));
    chk({tag, "_contagem"}, 32'(contagem), exp_q.size());
    chk({tag, "_vazio"},    32'(vazio),    32'(exp_q.size() == 0));
    chk({tag, "_cheio"},    32'(cheio),    32'(exp_q.size() == DEPTH));
    chk({tag, "_erro"},     32'(erro),     32'(m_err));
  endtask

  // driver: apply one cycle of inputs, predict from the pre-edge model, check after the edge
  task automatic step(input logic esc, input logic [WIDTH-1:0] d, input logic [AW-1:0] addr,
                      input logic zr, input string tag);
    escreve  = esc;
    D        = d;
    endereco = addr;
    zera     = zr;
    if (zr) begin
      model_clear();
    end else begin
      m_q = (int'(addr) < exp_q.size()) ? exp_q[addr] : '0;
      if (esc) begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(d);
          m_ult = d;
        end else begin
`ifdef REGISTRADOR_SEQUENCIA_SOBRESCRITA_EN
          void'(exp_q.pop_front());
          exp_q.push_back(d);
          m_ult = d;
`else
          m_err = 1'b1;
`endif
        end
      end
    end
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input logic [AW-1:0] addr, input string tag);
    step(1'b0, '0, addr, 1'b0, tag);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    clear_n  = 1'b0;
    zera     = 1'b0;
    escreve  = 1'b0;
    D        = '0;
    endereco = '0;
    model_clear();
    #2;
    check_all("reset");
    @(negedge clock);
    clear_n = 1'b1;

    // three writes then indexed reads, including one past the end
    step(1'b1, 8'h11, 4'd0, 1'b0, "w3_a");
    step(1'b1, 8'h22, 4'd0, 1'b0, "w3_b");
    step(1'b1, 8'h33, 4'd0, 1'b0, "w3_c");
    chk("w3_ultimo_const", 32'(ultimo), 32'h33);
    idle(4'd0, "w3_rd0");
    chk("w3_q0_const", 32'(Q), 32'h11);
    idle(4'd1, "w3_rd1");
    idle(4'd2, "w3_rd2");
    chk("w3_q2_const", 32'(Q), 32'h33);
    idle(4'd3, "w3_rd3");
    chk("w3_q3_const", 32'(Q), 32'h00);

    // fill to DEPTH, then one more write into a full buffer
    step(1'b0, '0, '0, 1'b1, "full_zera");
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i), 4'd0, 1'b0, "full_fill");
    step(1'b1, 8'hAA, 4'd0, 1'b0, "full_extra");
    idle(4'd0, "full_rd0");
    idle(4'd15, "full_rd15");
    idle(4'd7, "full_rd7");

    // zera wins over a simultaneous write
    step(1'b0, '0, '0, 1'b1, "zp_zera");
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'h40 + i), 4'd0, 1'b0, "zp_fill");
    step(1'b1, 8'h55, 4'd0, 1'b1, "zp_both");
    chk("zp_vazio_const", 32'(vazio), 32'd1);

    // read of index 0 on the very write edge sees nothing yet
    step(1'b1, 8'h7E, 4'd0, 1'b0, "lat_wr");
    chk("lat_q_wr_const", 32'(Q), 32'h00);
    idle(4'd0, "lat_rd");
    chk("lat_q_next_const", 32'(Q), 32'h7E);

    // asynchronous reset pulsed between edges
    for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(8'hC0 + i), 4'd1, 1'b0, "ar_fill");
    #2;
    clear_n = 1'b0;
    #1;
    model_clear();
    check_all("ar_low");
    clear_n = 1'b1;
    step(1'b1, 8'h9C, 4'd0, 1'b0, "ar_wr");
    idle(4'd0, "ar_rd");
    chk("ar_q_const", 32'(Q), 32'h9C);

    // reset held across an edge that carries a write
    escreve = 1'b1;
    D       = 8'h3C;
    clear_n = 1'b0;
    @(posedge clock);
    #1;
    model_clear();
    check_all("mw_abort");
    escreve = 1'b0;
    clear_n = 1'b1;
    step(1'b1, 8'h61, 4'd1, 1'b0, "mw_wr");
    idle(4'd0, "mw_rd");

    // 20 writes of 1..20 exercises pointer wrap (or overflow when not overwriting)
    step(1'b0, '0, '0, 1'b1, "wrap_zera");
    for (int i = 1; i <= 20; i++) step(1'b1, WIDTH'(i), 4'd0, 1'b0, "wrap_fill");
    idle(4'd0, "wrap_rd0");
    idle(4'd15, "wrap_rd15");
`ifdef REGISTRADOR_SEQUENCIA_SOBRESCRITA_EN
    chk("wrap_q15_const", 32'(Q), 32'd20);
`else
    chk("wrap_erro_const", 32'(erro), 32'd1);
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7), WIDTH'($urandom), AW'($urandom_range(0, DEPTH - 1)),
           ($urandom_range(0, 59) == 0), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/registrador_sequencia.md
REGISTRADOR_SEQUENCIA -- requirements
Module: registrador_sequencia

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each stored entry (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >=2; AW = clog2(DEPTH).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 clear_n  input  1  reset, asynchronous, active-low.
REQ-005 zera  input  1  synchronous clear, active-high.
REQ-006 escreve  input  1  append request, active-high, sampled on the rising edge.
REQ-007 D  input  WIDTH  data to append.
REQ-008 endereco  input  AW  logical read index; 0 = oldest stored entry.
REQ-009 Q  output  WIDTH  registered read data.
REQ-010 ultimo  output  WIDTH  registered copy of the most recently accepted entry.
REQ-011 contagem  output  AW+1  number of valid entries, 0..DEPTH.
REQ-012 vazio  output  1  high when contagem == 0.
REQ-013 cheio  output  1  high when contagem == DEPTH.
REQ-014 erro  output  1  sticky overflow flag.

Function
REQ-015 Storage is a circular buffer of DEPTH x WIDTH, with a base pointer (oldest entry) and a write pointer, both AW bits, wrapping modulo DEPTH.
REQ-016 An accepted write stores D at the write pointer, advances the write pointer by 1, and updates ultimo to D on the same edge.
REQ-017 With escreve=1, zera=0 and cheio=0, the write is accepted and contagem increments by 1.
REQ-018 Q is updated every cycle: Q = entry at (base + endereco) mod DEPTH if endereco < contagem, else all zeros; read latency is exactly 1 cycle.
REQ-019 The read condition and address use pre-edge contagem and pointers; a write on the same edge is not visible to Q until the next cycle.
REQ-020 zera=1 sets contagem, both pointers, Q, ultimo and erro to 0 on the next edge and has priority over escreve.
REQ-021 Memory contents are not cleared by zera or clear_n; entries at index >= contagem are never exposed on Q.
REQ-022 vazio and cheio are decoded combinationally from registered contagem only.
REQ-023 contagem never exceeds DEPTH and never wraps.

Reset
REQ-024 clear_n=0 immediately forces contagem=0, both pointers=0, Q=0, ultimo=0, erro=0, independent of clock.
REQ-025 Reset asserted mid-write aborts the write; after release the block is empty (vazio=1) and the first accepted write lands at physical index 0.

Configuration
REQ-026 Macro REGISTRADOR_SEQUENCIA_SOBRESCRITA_EN selects full-buffer write behaviour.
REQ-027 Without the macro, a write with cheio=1 is ignored: storage, pointers, contagem and ultimo are unchanged, and erro is set to 1 until zera or reset.
REQ-028 With the macro, a write with cheio=1 overwrites the oldest entry: both pointers advance by 1, contagem stays DEPTH, ultimo=D, and erro stays 0 permanently.

Verification
REQ-029 Reset then 3 writes of 0x11, 0x22, 0x33 -> contagem=3, vazio=0, ultimo=0x33; endereco=0/1/2 gives Q=0x11/0x22/0x33 one cycle later; endereco=3 gives Q=0x00.
REQ-030 16 writes of 0x00..0x0F (DEPTH=16), then write 0xAA -> cheio=1, contagem=16. Without the macro: erro=1, endereco=0 gives Q=0x00. With the macro: erro=0, endereco=0 gives Q=0x01, endereco=15 gives Q=0xAA.
REQ-031 escreve=1 with D=0x55 and zera=1 on the same edge, with 5 entries stored -> contagem=0, ultimo=0x00, Q=0x00, vazio=1.
REQ-032 Empty buffer, endereco=0, write 0x7E -> Q=0x00 on the write edge and Q=0x7E on the following edge.
REQ-033 clear_n pulsed low between edges after 4 writes -> outputs are zero before the next edge; the next write of 0x9C reads back at endereco=0.
REQ-034 Overwrite mode: 20 writes of 1..20 (DEPTH=16) -> endereco=0 gives Q=5, endereco=15 gives Q=20; this checks pointer wrap-around.
